// File: rtl/led_matrix_pkg.sv
// led_matrix_pkg: shared types and sizes for the LED matrix controller
package led_matrix_pkg;
    localparam int NROWS = 8;
    localparam int ROW_W = 8;
    typedef enum logic [1:0] {IDLE, CLEAR, WRITE} state_t;
    typedef struct packed {
        logic             clr;
        logic             wr;
        logic [2:0]       row;
        logic [ROW_W-1:0] val;
    } slot_t;
endpackage

// File: rtl/led_matrix_ctrl_if.sv
// led_matrix_ctrl_if: requester ports and matrix drive outputs of the controller
interface led_matrix_ctrl_if;
    logic       wr_a;
    logic       clr_a;
    logic [2:0] row_a;
    logic [7:0] val_a;
    logic       ack_a;
    logic       wr_b;
    logic       clr_b;
    logic [2:0] row_b;
    logic [7:0] val_b;
    logic       ack_b;
    logic [1:0] ovf;
    logic [7:0] row_n;
    logic [7:0] col;
    logic       frame_tick;
    modport master (
        output wr_a, clr_a, row_a, val_a, wr_b, clr_b, row_b, val_b,
        input  ack_a, ack_b, ovf, row_n, col, frame_tick
    );
    modport slave (
        input  wr_a, clr_a, row_a, val_a, wr_b, clr_b, row_b, val_b,
        output ack_a, ack_b, ovf, row_n, col, frame_tick
    );
endinterface

// File: rtl/led_matrix_ctrl_scan.sv
// matrix_scan: row-multiplexed drive with per-slot blanking and frame tick
module matrix_scan
    import led_matrix_pkg::*;
#(
    parameter int SCAN_DIV  = 1024,
    parameter int BLANK_CYC = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NROWS*ROW_W-1:0] i_buf,
    output logic [7:0]             o_row_n,
    output logic [7:0]             o_col,
    output logic                   o_frame_tick
);
    localparam int DW = $clog2(SCAN_DIV);
    logic [DW-1:0] r_div;
    logic [2:0]    r_row;
    logic [7:0]    r_row_n;
    logic [7:0]    r_col;
    logic          r_frame_tick;
    logic          w_tc;
    logic          w_blank;
    logic [DW-1:0] w_div_nxt;
    logic [2:0]    w_row_nxt;
    assign w_tc      = r_div == DW'(SCAN_DIV - 1);
    assign w_div_nxt = w_tc ? '0 : r_div + 1'b1;
    assign w_row_nxt = w_tc ? r_row + 3'd1 : r_row;
    assign w_blank   = w_div_nxt < DW'(BLANK_CYC);
    // Outputs are built from the next divider/row so they line up with r_div.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div        <= '0;
            r_row        <= '0;
            r_row_n      <= 8'hFF;
            r_col        <= 8'h00;
            r_frame_tick <= 1'b0;
        end else begin
            r_div        <= w_div_nxt;
            r_row        <= w_row_nxt;
            r_frame_tick <= w_tc && r_row == 3'd7;
            r_row_n      <= w_blank ? 8'hFF : ~(8'd1 << w_row_nxt);
            r_col        <= w_blank ? 8'h00 : i_buf[{w_row_nxt, 3'b000} +: ROW_W];
        end
    end
    assign o_row_n      = r_row_n;
    assign o_col        = r_col;
    assign o_frame_tick = r_frame_tick;
endmodule

// File: rtl/led_matrix_ctrl.sv
// led_matrix_ctrl: 8x8 frame buffer with two-port arbitration, sequenced clears and row scan
module led_matrix_ctrl
    import led_matrix_pkg::*;
#(
    parameter int SCAN_DIV  = 1024,
    parameter int BLANK_CYC = 16
) (
    input logic               clk,
    input logic               reset,
    led_matrix_ctrl_if.slave  bus
);
    logic [ROW_W-1:0]       r_buf [NROWS];
    slot_t                  r_slot_a;
    slot_t                  r_slot_b;
    state_t                 r_state;
    logic [2:0]             r_cnt;
    logic                   r_sel_b;
    logic                   r_ack_a;
    logic                   r_ack_b;
    logic [1:0]             r_ovf;
    logic                   w_full_a;
    logic                   w_full_b;
    logic                   w_stb_a;
    logic                   w_stb_b;
    logic                   w_cur_b;
    logic                   w_done;
    logic                   w_free_a;
    logic                   w_free_b;
    slot_t                  w_cur;
    logic [NROWS*ROW_W-1:0] w_buf_flat;
    assign w_full_a = r_slot_a.clr | r_slot_a.wr;
    assign w_full_b = r_slot_b.clr | r_slot_b.wr;
    assign w_stb_a  = bus.wr_a | bus.clr_a;
    assign w_stb_b  = bus.wr_b | bus.clr_b;
    // In IDLE A wins whenever it holds work; otherwise the latched owner is served.
    assign w_cur_b  = (r_state == IDLE) ? !w_full_a : r_sel_b;
    assign w_cur    = w_cur_b ? r_slot_b : r_slot_a;
    assign w_done   = (r_state == IDLE && w_cur.wr && !w_cur.clr) ||
                      (r_state == CLEAR && r_cnt == 3'd7 && !w_cur.wr) ||
                      (r_state == WRITE);
    assign w_free_a = w_done && !w_cur_b;
    assign w_free_b = w_done && w_cur_b;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot_a <= '0;
            r_slot_b <= '0;
            r_ovf    <= 2'b00;
        end else begin
            r_slot_a <= w_stb_a ? slot_t'{bus.clr_a, bus.wr_a, bus.row_a, bus.val_a} :
                        w_free_a ? '0 : r_slot_a;
            r_slot_b <= w_stb_b ? slot_t'{bus.clr_b, bus.wr_b, bus.row_b, bus.val_b} :
                        w_free_b ? '0 : r_slot_b;
            r_ovf    <= r_ovf | {w_stb_b & w_full_b & ~w_free_b, w_stb_a & w_full_a & ~w_free_a};
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sel_b <= 1'b0;
            r_ack_a <= 1'b0;
            r_ack_b <= 1'b0;
            for (int i = 0; i < NROWS; i++) r_buf[i] <= '0;
        end else begin
            r_ack_a <= w_free_a;
            r_ack_b <= w_free_b;
            case (r_state)
                IDLE: begin
                    if (w_cur.clr) begin
                        r_state <= CLEAR;
                        r_cnt   <= '0;
                        r_sel_b <= w_cur_b;
                    end else if (w_cur.wr) begin
                        r_buf[w_cur.row] <= w_cur.val;
                    end
                end
                CLEAR: begin
                    r_buf[r_cnt] <= '0;
                    r_cnt        <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) r_state <= w_cur.wr ? WRITE : IDLE;
                end
                WRITE: begin
                    r_buf[w_cur.row] <= w_cur.val;
                    r_state          <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    for (genvar g = 0; g < NROWS; g++) begin : g_flat
        assign w_buf_flat[g*ROW_W +: ROW_W] = r_buf[g];
    end
    assign bus.ack_a = r_ack_a;
    assign bus.ack_b = r_ack_b;
    assign bus.ovf   = r_ovf;
    matrix_scan #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) u_scan (
        .clk          (clk),
        .reset        (reset),
        .i_buf        (w_buf_flat),
        .o_row_n      (bus.row_n),
        .o_col        (bus.col),
        .o_frame_tick (bus.frame_tick)
    );
endmodule

// File: tb/tb_led_matrix_ctrl.sv
// tb_led_matrix_ctrl: directed scenario tasks for led_matrix_ctrl with small scan period
module tb_led_matrix_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    led_matrix_ctrl_if bus();
    led_matrix_ctrl #(.SCAN_DIV(32), .BLANK_CYC(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        bus.wr_a = 0; bus.clr_a = 0; bus.row_a = 0; bus.val_a = 0;
        bus.wr_b = 0; bus.clr_b = 0; bus.row_b = 0; bus.val_b = 0;
    endtask

    task automatic test_reset();
        quiet_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
        n_tests++; if (bus.row_n !== 8'hFF) begin n_fail++; $display("FAIL reset_row_n got %h want FF", bus.row_n); end
        n_tests++; if (bus.col !== 8'h00) begin n_fail++; $display("FAIL reset_col got %h want 00", bus.col); end
        n_tests++; if (bus.ack_a !== 1'b0 || bus.ack_b !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b%b want 00", bus.ack_a, bus.ack_b); end
        n_tests++; if (bus.ovf !== 2'b00) begin n_fail++; $display("FAIL reset_ovf got %b want 00", bus.ovf); end
        n_tests++; if (bus.frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_frame_tick got %b want 0", bus.frame_tick); end
        n_tests++; if (dut.w_buf_flat !== 64'h0) begin n_fail++; $display("FAIL reset_buf got %h want 0", dut.w_buf_flat); end
    endtask

    task automatic test_scan();
        logic [7:0] exp_rn;
        int ticks = 0;
        int first = 0;
        for (int k = 1; k <= 512; k++) begin
            tick();
            exp_rn = ((k % 32) < 4) ? 8'hFF : ~(8'd1 << ((k / 32) % 8));
            n_tests++;
            if (bus.row_n !== exp_rn) begin n_fail++; $display("FAIL scan_row_n k=%0d got %h want %h", k, bus.row_n, exp_rn); end
            if (bus.frame_tick === 1'b1) begin
                ticks++;
                if (first == 0) first = k;
            end
        end
        n_tests++; if (ticks !== 2) begin n_fail++; $display("FAIL frame_tick_count got %0d want 2", ticks); end
        n_tests++; if (first !== 256) begin n_fail++; $display("FAIL frame_tick_first got %0d want 256", first); end
    endtask

    task automatic test_write();
        int i;
        bus.wr_a = 1; bus.row_a = 3; bus.val_a = 8'hE0;
        tick();
        bus.wr_a = 0;
        n_tests++; if (dut.w_buf_flat[31:24] !== 8'h00 || bus.ack_a !== 1'b0) begin n_fail++; $display("FAIL write_early buf %h ack %b want 00 0", dut.w_buf_flat[31:24], bus.ack_a); end
        tick();
        n_tests++; if (dut.w_buf_flat[31:24] !== 8'hE0) begin n_fail++; $display("FAIL write_buf got %h want E0", dut.w_buf_flat[31:24]); end
        n_tests++; if (bus.ack_a !== 1'b1 || bus.ack_b !== 1'b0) begin n_fail++; $display("FAIL write_ack got %b%b want 10", bus.ack_a, bus.ack_b); end
        tick();
        n_tests++; if (bus.ack_a !== 1'b0) begin n_fail++; $display("FAIL write_ack_width got %b want 0", bus.ack_a); end
        for (i = 0; i < 400 && bus.row_n !== 8'hF7; i++) tick();
        n_tests++; if (bus.row_n !== 8'hF7) begin n_fail++; $display("FAIL write_scan_row got %h want F7", bus.row_n); end
        n_tests++; if (bus.col !== 8'hE0) begin n_fail++; $display("FAIL write_scan_col got %h want E0", bus.col); end
    endtask

    task automatic test_clear();
        int acks = 0;
        int ack_at = 0;
        for (int i = 0; i < 8; i++) begin
            bus.wr_a = 1; bus.row_a = 3'(i); bus.val_a = 8'hFF;
            tick();
        end
        bus.wr_a = 0;
        tick();
        tick();
        n_tests++; if (dut.w_buf_flat !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL fill_buf got %h want all FF", dut.w_buf_flat); end
        bus.clr_a = 1; bus.wr_a = 1; bus.row_a = 0; bus.val_a = 8'hE0;
        tick();
        bus.clr_a = 0; bus.wr_a = 0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (bus.ack_a === 1'b1) begin acks++; ack_at = k; end
        end
        n_tests++; if (acks !== 1) begin n_fail++; $display("FAIL clear_ack_count got %0d want 1", acks); end
        n_tests++; if (ack_at !== 10) begin n_fail++; $display("FAIL clear_ack_cycle got %0d want 10", ack_at); end
        n_tests++; if (dut.w_buf_flat !== 64'h0000_0000_0000_00E0) begin n_fail++; $display("FAIL clear_buf got %h want E0 in row 0 only", dut.w_buf_flat); end
    endtask

    task automatic test_back_to_back();
        bus.wr_a = 1; bus.row_a = 2; bus.val_a = 8'h0F;
        bus.wr_b = 1; bus.row_b = 2; bus.val_b = 8'hF0;
        tick();
        quiet_inputs();
        tick();
        n_tests++; if (bus.ack_a !== 1'b1 || bus.ack_b !== 1'b0) begin n_fail++; $display("FAIL b2b_first_ack got %b%b want 10", bus.ack_a, bus.ack_b); end
        n_tests++; if (dut.w_buf_flat[23:16] !== 8'h0F) begin n_fail++; $display("FAIL b2b_first_buf got %h want 0F", dut.w_buf_flat[23:16]); end
        tick();
        n_tests++; if (bus.ack_a !== 1'b0 || bus.ack_b !== 1'b1) begin n_fail++; $display("FAIL b2b_second_ack got %b%b want 01", bus.ack_a, bus.ack_b); end
        n_tests++; if (dut.w_buf_flat[23:16] !== 8'hF0) begin n_fail++; $display("FAIL b2b_final_buf got %h want F0", dut.w_buf_flat[23:16]); end
        tick();
        n_tests++; if (bus.ovf !== 2'b00) begin n_fail++; $display("FAIL b2b_ovf got %b want 00", bus.ovf); end
    endtask

    task automatic test_overflow();
        int acks_a = 0;
        int acks_b = 0;
        int both = 0;
        bus.clr_a = 1;
        tick();
        bus.clr_a = 0;
        tick();
        bus.wr_b = 1; bus.row_b = 5; bus.val_b = 8'h11;
        tick();
        bus.val_b = 8'h22;
        tick();
        bus.wr_b = 0;
        n_tests++; if (bus.ovf !== 2'b10) begin n_fail++; $display("FAIL ovf_flags got %b want 10", bus.ovf); end
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bus.ack_a === 1'b1) acks_a++;
            if (bus.ack_b === 1'b1) acks_b++;
            if (bus.ack_a === 1'b1 && bus.ack_b === 1'b1) both++;
        end
        n_tests++; if (acks_a !== 1 || acks_b !== 1) begin n_fail++; $display("FAIL ovf_acks got a=%0d b=%0d want 1 1", acks_a, acks_b); end
        n_tests++; if (both !== 0) begin n_fail++; $display("FAIL ovf_dual_ack got %0d want 0", both); end
        n_tests++; if (dut.w_buf_flat !== 64'h0000_2200_0000_0000) begin n_fail++; $display("FAIL ovf_buf got %h want 22 in row 5 only", dut.w_buf_flat); end
        n_tests++; if (bus.ovf !== 2'b10) begin n_fail++; $display("FAIL ovf_sticky got %b want 10", bus.ovf); end
    endtask

    task automatic test_reset_mid_clear();
        int acks = 0;
        bus.wr_a = 1; bus.row_a = 4; bus.val_a = 8'h5A;
        tick();
        bus.wr_a = 0;
        tick();
        bus.clr_a = 1;
        tick();
        bus.clr_a = 0;
        tick();
        tick();
        tick();
        tick();
        n_tests++; if (dut.w_buf_flat[39:32] !== 8'h5A || dut.w_buf_flat[7:0] !== 8'h00) begin n_fail++; $display("FAIL midclear_buf got r4=%h r0=%h want 5A 00", dut.w_buf_flat[39:32], dut.w_buf_flat[7:0]); end
        reset = 1;
        tick();
        n_tests++; if (bus.row_n !== 8'hFF || bus.col !== 8'h00) begin n_fail++; $display("FAIL rst_mid_drive got %h %h want FF 00", bus.row_n, bus.col); end
        n_tests++; if (bus.ack_a !== 1'b0 || bus.ack_b !== 1'b0 || bus.frame_tick !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pulses got %b%b%b want 000", bus.ack_a, bus.ack_b, bus.frame_tick); end
        n_tests++; if (bus.ovf !== 2'b00) begin n_fail++; $display("FAIL rst_mid_ovf got %b want 00", bus.ovf); end
        n_tests++; if (dut.w_buf_flat !== 64'h0) begin n_fail++; $display("FAIL rst_mid_buf got %h want 0", dut.w_buf_flat); end
        reset = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (bus.ack_a === 1'b1 || bus.ack_b === 1'b1) acks++;
        end
        n_tests++; if (acks !== 0) begin n_fail++; $display("FAIL rst_mid_no_ack got %0d want 0", acks); end
        n_tests++; if (dut.w_buf_flat !== 64'h0) begin n_fail++; $display("FAIL rst_mid_buf_after got %h want 0", dut.w_buf_flat); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_write();
        test_clear();
        test_back_to_back();
        test_overflow();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
